// File: rtl/operand_loader_pkg.sv
// Shared types and constants for operand_loader.
package operand_loader_pkg;

    localparam int DEFAULT_DATA_W = 32;

    // Assembly phase: first operand, second operand, pair waiting for consumer.
    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/operand_loader_byte_lane_writer.sv
// byte_lane_writer: writes one byte into a DATA_W register at a lane index.
// Lane mapping is little-endian by default; defining OPERAND_LOADER_BE_EN
// maps byte index 0 to the most significant lane instead.
module byte_lane_writer
    import operand_loader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_data
);

    localparam int NBYTES = DATA_W / 8;

    logic [IDX_W-1:0]  w_lane;
    logic [DATA_W-1:0] r_data;

`ifdef OPERAND_LOADER_BE_EN
    assign w_lane = IDX_W'(NBYTES - 1) - i_idx;
`else
    assign w_lane = i_idx;
`endif

    // Overwrite only the addressed lane; other lanes keep their old bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (w_lane == IDX_W'(k)) begin
                    r_data[8*k +: 8] <= i_byte;
                end
            end
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: assembles two DATA_W operands from a byte stream and
// presents them as a pair to a downstream adder with valid/ready handshakes.
// Optional macro OPERAND_LOADER_BE_EN selects big-endian byte placement.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] di1,
    output logic [DATA_W-1:0] di2,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic w_byte_fire;
    logic w_pair_fire;
    logic w_last;
    logic w_we_a;
    logic w_we_b;

    // A clr edge discards any handshake that coincides with it.
    assign w_byte_fire = in_valid && r_in_ready && !clr;
    assign w_pair_fire = r_out_valid && out_ready && !clr;
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_we_a      = w_byte_fire && (r_state == LOAD_A);
    assign w_we_b      = w_byte_fire && (r_state == LOAD_B);

    // Sequencing FSM with byte counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LOAD_A;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= LOAD_A;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_byte_fire) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_byte_fire) begin
                        if (w_last) begin
                            r_cnt       <= '0;
                            r_state     <= PRESENT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (w_pair_fire) begin
                        r_state     <= LOAD_A;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= LOAD_A;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    byte_lane_writer #(.DATA_W(DATA_W), .IDX_W(CNT_W)) u_lane_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_a),
        .i_idx  (r_cnt),
        .i_byte (in_data),
        .o_data (di1)
    );

    byte_lane_writer #(.DATA_W(DATA_W), .IDX_W(CNT_W)) u_lane_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_b),
        .i_idx  (r_cnt),
        .i_byte (in_data),
        .o_data (di2)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand width in bits; it SHALL be a multiple of 8 and at least 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port clr, input, 1, a synchronous flush of any partial assembly.
REQ-005 The block SHALL have port in_data, input, 8, the incoming operand byte.
REQ-006 The block SHALL have port in_valid, input, 1, marking in_data as valid.
REQ-007 The block SHALL have port in_ready, output, 1, showing the block can accept a byte.
REQ-008 The block SHALL have port di1, output, DATA_W, the first operand, driven to the downstream 32-bit adder.
REQ-009 The block SHALL have port di2, output, DATA_W, the second operand, driven to the downstream adder.
REQ-010 The block SHALL have port out_valid, output, 1, marking di1/di2 as a complete operand pair.
REQ-011 The block SHALL have port out_ready, input, 1, the consumer's acceptance of the pair.

Function
REQ-012 A byte SHALL transfer on a rising edge only when in_valid=1 and in_ready=1; a pair SHALL transfer only when out_valid=1 and out_ready=1.
REQ-013 The FSM SHALL have three states:
- LOAD_A: in_ready=1, out_valid=0.
- LOAD_B: in_ready=1, out_valid=0.
- PRESENT: in_ready=0, out_valid=1.
REQ-014 A byte counter of width clog2(DATA_W/8) SHALL advance on each accepted byte and wrap to 0 after DATA_W/8 bytes.
REQ-015 On the last byte of an operand, the FSM SHALL move LOAD_A->LOAD_B or LOAD_B->PRESENT, and the counter SHALL wrap to 0.
REQ-016 Byte k (k=0 first) SHALL land in bits [8k+7:8k] of the operand being loaded (little-endian).
REQ-017 out_valid SHALL assert in the cycle after the final byte of di2 is accepted, giving one cycle of latency.
REQ-018 In PRESENT, di1, di2 and out_valid SHALL stay stable until the pair transfers, then the FSM SHALL return to LOAD_A.
REQ-019 In PRESENT, in_valid SHALL be ignored; in_ready=0 in PRESENT, so bytes cannot be accepted and pairs cannot overlap.
REQ-020 di1/di2 bits not yet written in the current pass SHALL hold their previous values; bytes SHALL be overwritten, never cleared.
REQ-021 When clr=1, the FSM SHALL go to LOAD_A and the counter to 0 on that edge, in any state.
REQ-022 A simultaneous byte or pair handshake on a clr edge SHALL be discarded.
REQ-023 clr SHALL leave di1/di2 unchanged.

Reset
REQ-024 While rst_n=0 at a rising edge, the FSM SHALL go to LOAD_A, the counter SHALL go to 0, and di1, di2 and out_valid SHALL go to 0.
REQ-025 rst_n SHALL take priority over clr and over all handshakes.
REQ-026 A reset applied mid-operand or in PRESENT SHALL drop the partial or pending pair without emitting it.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 With macro OPERAND_LOADER_BE_EN defined, byte k SHALL land in bits [DATA_W-1-8k : DATA_W-8-8k] (big-endian); without it, REQ-016 SHALL apply.
REQ-029 Handshake behaviour and timing SHALL be identical with and without OPERAND_LOADER_BE_EN.

Structure
REQ-030 Package operand_loader_pkg SHALL hold the FSM state enum (LOAD_A, LOAD_B, PRESENT) and the constant DEFAULT_DATA_W=32.
REQ-031 Sub-module byte_lane_writer SHALL be instantiated twice, once per operand, and SHALL write one byte into a DATA_W register at a given lane index on a write enable, with the endianness mapping selected by the macro.
REQ-032 The FSM, the counter and the handshake SHALL live in operand_loader.

Verification
REQ-033 Back-to-back bytes 01,02,03,04,10,20,30,40 with out_ready=1 -> di1=32'h04030201, di2=32'h40302010, out_valid high exactly 1 cycle, in_ready=1 again the next cycle.
REQ-034 The same bytes with out_ready=0 for 5 cycles -> out_valid held and di1/di2 stable for 5 cycles; in_data toggling in that window has no effect.
REQ-035 Three bytes AA,BB,CC, then clr=1 together with in_valid=1 and byte DD, then the eight bytes of REQ-033 -> first pair di1=32'h04030201; AA/BB/CC/DD never appear in any output pair.
REQ-036 rst_n=0 for one cycle while in PRESENT -> next cycle out_valid=0, di1=di2=0, in_ready=1.
REQ-037 Build with OPERAND_LOADER_BE_EN and send the REQ-033 bytes -> di1=32'h01020304, di2=32'h10203040.
REQ-038 Random in_valid/out_ready gaps over 1000 pairs -> each pair matches the scoreboard and no byte is lost or duplicated.
